// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage plus IF/ID pipeline register feeding the main
//   control unit. Holds the PC, fetches from instruction memory over a
//   req/valid handshake, applies jump/branch redirects, flushes and stalls,
//   and presents the fetched word with its PC+4.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   imem_req/imem_addr      fetch request, held with a stable address until
//                           imem_valid
//   imem_valid/imem_rdata   returned instruction word
//   stall, flush            hazard stall / IF/ID invalidate
//   jump, jump_target       redirect (priority over branch)
//   branch_taken/_target    redirect
//   if_id_instr/_pc4/_valid IF/ID pipeline register
//   if_opcode               if_id_instr[31:26] to the control unit
//   perf_fetched/_stalls    performance counters
//
// Configuration
//   IF_PERF_CNT_EN  when defined, perf_fetched counts IF/ID loads with
//                   valid=1 and perf_stalls counts stall cycles (32-bit,
//                   wrapping). When undefined both ports are tied to 0.
// ----------------------------------------------------------------------------
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        flush,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic [5:0]  if_opcode,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stalls
);

   // RUN : request outstanding at req_addr
   // HOLD: word captured in the skid while stalled, no request
   // DROP: a redirect arrived mid-request; the in-flight word is discarded
   typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, DROP = 2'd2} state_t;

   state_t      state_q, state_d;
   logic        started_q;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic [31:0] skid_q, skid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;

   logic        redirect;
   logic [31:0] target;
   logic [31:0] next_addr;
   logic        deliver;
   logic [31:0] deliver_word;

   assign redirect  = jump | branch_taken;
   assign target    = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
   assign next_addr = req_addr_q + 32'd4;

   // started_q keeps the request low for the first cycle out of reset
   assign imem_req  = started_q & (state_q != HOLD);
   assign imem_addr = req_addr_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_addr_d   = req_addr_q;
      skid_d       = skid_q;
      deliver      = 1'b0;
      deliver_word = imem_rdata;

      case (state_q)
         RUN: begin
            if (!started_q) begin
               // nothing in flight yet, so a redirect can retarget directly
               if (redirect) begin
                  pc_d       = target;
                  req_addr_d = target;
               end
            end else if (redirect) begin
               pc_d = target;
               if (imem_valid) req_addr_d = target;
               else            state_d    = DROP;
            end else if (imem_valid) begin
               if (stall) begin
                  skid_d  = imem_rdata;
                  state_d = HOLD;
               end else begin
                  deliver = 1'b1;
               end
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_d       = target;
               req_addr_d = target;
               state_d    = RUN;
            end else if (!stall) begin
               deliver      = 1'b1;
               deliver_word = skid_q;
               state_d      = RUN;
            end
         end
         DROP: begin
            // latest redirect wins, including one landing with the late word
            if (redirect) pc_d = target;
            if (imem_valid) begin
               req_addr_d = redirect ? target : pc_q;
               state_d    = RUN;
            end
         end
         default: state_d = RUN;
      endcase

      if (deliver) begin
         pc_d       = next_addr;
         req_addr_d = next_addr;
      end

      // IF/ID: redirect/flush beat stall; an unstalled cycle with nothing
      // delivered becomes a bubble so ID never re-executes a word
      valid_d = valid_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      if (redirect | flush) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end else if (deliver) begin
         valid_d = 1'b1;
         instr_d = deliver_word;
         pc4_d   = next_addr;
      end else if (!stall) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         started_q  <= 1'b0;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         skid_q     <= 32'd0;
         instr_q    <= NOP_INSTR;
         pc4_q      <= 32'd0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         started_q  <= 1'b1;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         skid_q     <= skid_d;
         instr_q    <= instr_d;
         pc4_q      <= pc4_d;
         valid_q    <= valid_d;
      end
   end

   assign if_id_instr = instr_q;
   assign if_id_pc4   = pc4_q;
   assign if_id_valid = valid_q;
   assign if_opcode   = instr_q[31:26];

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetched_q, stalls_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetched_q <= 32'd0;
         stalls_q  <= 32'd0;
      end else begin
         // a flushed delivery loads IF/ID invalid and is not counted
         if (deliver && !flush) fetched_q <= fetched_q + 32'd1;
         if (stall)             stalls_q  <= stalls_q + 32'd1;
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_stalls  = stalls_q;
`else
   assign perf_fetched = 32'd0;
   assign perf_stalls  = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        stall = 1'b0, flush = 1'b0, jump = 1'b0, branch_taken = 1'b0;
   logic [31:0] jump_target = 32'd0, branch_target = 32'd0;
   logic [31:0] if_id_instr, if_id_pc4;
   logic        if_id_valid;
   logic [5:0]  if_opcode;
   logic [31:0] perf_fetched, perf_stalls;

   if_fetch_stage dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_rdata(imem_rdata),
      .stall(stall), .flush(flush),
      .jump(jump), .jump_target(jump_target),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
      .if_opcode(if_opcode), .perf_fetched(perf_fetched), .perf_stalls(perf_stalls)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Tracked as "is a request on the bus", "is the in-flight word stale",
   // "is a word parked waiting for the stall to clear".
   bit          m_started, m_stale, m_parked;
   logic [31:0] m_pc, m_ra, m_park_w;
   logic        m_v;
   logic [31:0] m_instr, m_pc4, m_fetched, m_stalls;
   bit          fixed_word;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return fixed_word ? 32'h2008_0005 : (a * 32'h9E37_79B1 + 32'h1234_5677);
   endfunction

   function automatic bit m_req();
      return m_started && !m_parked;
   endfunction

   task automatic model_reset();
      m_started = 0; m_stale = 0; m_parked = 0;
      m_pc = 32'd0; m_ra = 32'd0; m_park_w = 32'd0;
      m_v = 1'b0; m_instr = 32'd0; m_pc4 = 32'd0;
      m_fetched = 32'd0; m_stalls = 32'd0;
   endtask

   task automatic model_step();
      bit          redir, got, del;
      logic [31:0] tgt, w;
      redir = jump | branch_taken;
      tgt   = (jump ? jump_target : branch_target) & ~32'd3;
      got   = m_req() && imem_valid;
      del   = 0;
      w     = 32'd0;
      if (m_parked) begin
         if (redir) begin m_parked = 0; m_pc = tgt; m_ra = tgt; end
         else if (!stall) begin del = 1; w = m_park_w; m_parked = 0; end
      end else if (m_stale) begin
         if (redir) m_pc = tgt;
         if (got) begin m_stale = 0; m_ra = m_pc; end
      end else if (m_started) begin
         if (redir) begin
            m_pc = tgt;
            if (got) m_ra = tgt; else m_stale = 1;
         end else if (got) begin
            if (stall) begin m_parked = 1; m_park_w = imem_rdata; end
            else begin del = 1; w = imem_rdata; end
         end
      end else if (redir) begin
         m_pc = tgt; m_ra = tgt;
      end
      m_started = 1;
      if (redir || flush) begin
         m_v = 0; m_instr = 32'd0;
         if (del) begin m_pc = m_ra + 4; m_ra = m_ra + 4; end
      end else if (del) begin
         m_v = 1; m_instr = w; m_pc4 = m_ra + 4;
         m_pc = m_ra + 4; m_ra = m_ra + 4;
         m_fetched = m_fetched + 1;
      end else if (!stall) begin
         m_v = 0; m_instr = 32'd0;
      end
      if (stall) m_stalls = m_stalls + 1;
   endtask

   task automatic compare_all();
      chk("imem_req",    imem_req,    m_req());
      chk("imem_addr",   imem_addr,   m_ra);
      chk("if_id_valid", if_id_valid, m_v);
      chk("if_id_instr", if_id_instr, m_instr);
      chk("if_id_pc4",   if_id_pc4,   m_pc4);
      chk("if_opcode",   if_opcode,   m_instr[31:26]);
`ifdef IF_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_stalls",  perf_stalls,  m_stalls);
`else
      chk("perf_fetched", perf_fetched, 32'd0);
      chk("perf_stalls",  perf_stalls,  32'd0);
`endif
   endtask

   // Drive inputs mid-cycle, clock once, update model, check #1 after edge.
   task automatic cycle(input bit v, input bit st, input bit fl, input bit j,
                        input bit b, input logic [31:0] jt, input logic [31:0] bt);
      imem_valid    = v && m_req();
      imem_rdata    = mem_word(m_ra);
      stall         = st;
      flush         = fl;
      jump          = j;
      branch_taken  = b;
      jump_target   = jt;
      branch_target = bt;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      imem_valid = 0; stall = 0; flush = 0; jump = 0; branch_taken = 0;
      model_reset();
      #1;
      chk("rst imem_req",    imem_req,    1'b0);
      chk("rst imem_addr",   imem_addr,   32'd0);
      chk("rst if_id_valid", if_id_valid, 1'b0);
      chk("rst if_id_instr", if_id_instr, 32'd0);
      chk("rst if_id_pc4",   if_id_pc4,   32'd0);
      chk("rst perf_fetched", perf_fetched, 32'd0);
      chk("rst perf_stalls",  perf_stalls,  32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      fixed_word = 1;
      do_reset();

      // 1: back-to-back fetch of a fixed addi word
      cycle(1, 0, 0, 0, 0, 0, 0);
      chk("t1 req rises", imem_req, 1'b1);
      chk("t1 addr0", imem_addr, 32'd0);
      cycle(1, 0, 0, 0, 0, 0, 0);
      chk("t1 addr4", imem_addr, 32'd4);
      chk("t1 pc4", if_id_pc4, 32'd4);
      chk("t1 opcode", if_opcode, 6'b001000);
      cycle(1, 0, 0, 0, 0, 0, 0);
      chk("t1 addr8", imem_addr, 32'd8);

      // 2: stall across a returning word
      fixed_word = 0;
      cycle(1, 1, 0, 0, 0, 0, 0);
      chk("t2 hold req", imem_req, 1'b0);
      repeat (2) cycle(1, 1, 0, 0, 0, 0, 0);
      chk("t2 frozen pc4", if_id_pc4, 32'd8);
      chk("t2 frozen instr", if_id_instr, 32'h2008_0005);
      cycle(1, 0, 0, 0, 0, 0, 0);
      chk("t2 released pc4", if_id_pc4, 32'd12);
      chk("t2 released word", if_id_instr, 32'd8 * 32'h9E37_79B1 + 32'h1234_5677);
      cycle(0, 0, 0, 0, 0, 0, 0);
      chk("t2 no duplicate", if_id_valid, 1'b0);

      // 3: jump while request pending, late word dropped
      cycle(0, 0, 0, 1, 0, 32'h40, 0);
      chk("t3 addr stable", imem_addr, 32'd12);
      cycle(1, 0, 0, 0, 0, 0, 0);
      chk("t3 retarget", imem_addr, 32'h40);
      chk("t3 dropped", if_id_valid, 1'b0);
      cycle(1, 0, 0, 0, 0, 0, 0);
      chk("t3 pc4", if_id_pc4, 32'h44);

      // 4: jump beats branch
      cycle(1, 0, 0, 1, 1, 32'h80, 32'hC0);
      chk("t4 addr", imem_addr, 32'h80);
      chk("t4 invalid", if_id_valid, 1'b0);
      cycle(1, 0, 0, 0, 0, 0, 0);
      chk("t4 pc4", if_id_pc4, 32'h84);

      // 5: reset mid-request
      cycle(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      do_reset();
      cycle(0, 0, 0, 0, 0, 0, 0);
      chk("t5 refetch", imem_addr, 32'd0);

      // 6: 10 deliveries, 4 stall cycles
      repeat (3) cycle(1, 0, 0, 0, 0, 0, 0);
      repeat (4) cycle(1, 1, 0, 0, 0, 0, 0);
      repeat (7) cycle(1, 0, 0, 0, 0, 0, 0);
`ifdef IF_PERF_CNT_EN
      chk("t6 fetched", perf_fetched, 32'd10);
      chk("t6 stalls", perf_stalls, 32'd4);
`else
      chk("t6 fetched off", perf_fetched, 32'd0);
      chk("t6 stalls off", perf_stalls, 32'd0);
`endif

      // random mix
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2,
               $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 19) == 0, $urandom, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, fails);
      $finish;
   end

endmodule
